// File: rtl/biu_sram_responder_pkg.sv
// Shared BIU definitions for the SRAM responder: transfer size/type encodings
// and the burst-shape helper functions.
package biu_sram_responder_pkg;

    typedef enum logic [2:0] {
        BYTE  = 3'd0,
        HWORD = 3'd1,
        WORD  = 3'd2,
        DWORD = 3'd3
    } biu_size_t;

    typedef enum logic [2:0] {
        SINGLE = 3'd0,
        INCR   = 3'd1,
        WRAP4  = 3'd2,
        INCR4  = 3'd3,
        WRAP8  = 3'd4,
        INCR8  = 3'd5,
        WRAP16 = 3'd6,
        INCR16 = 3'd7
    } biu_type_t;

    typedef logic [2:0] biu_prot_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } resp_state_t;

    // Beats remaining after beat 0 (undefined-length INCR is served as one beat)
    function automatic logic [3:0] biu_type2cnt(biu_type_t t);
        logic [3:0] cnt;
        case (t)
            SINGLE, INCR:   cnt = 4'd0;
            WRAP4, INCR4:   cnt = 4'd3;
            WRAP8, INCR8:   cnt = 4'd7;
            WRAP16, INCR16: cnt = 4'd15;
            default:        cnt = 4'd0;
        endcase
        return cnt;
    endfunction

    function automatic logic [7:0] biu_size2bytes(biu_size_t s);
        return 8'd1 << s;
    endfunction

    function automatic logic biu_is_wrap(biu_type_t t);
        logic w;
        case (t)
            WRAP4, WRAP8, WRAP16: w = 1'b1;
            default:              w = 1'b0;
        endcase
        return w;
    endfunction

    // Low address bits that rotate inside a wrapping burst window
    function automatic logic [7:0] biu_wrap_mask(biu_type_t t, biu_size_t s);
        logic [7:0] m;
        if (biu_is_wrap(t)) begin
            m = (({4'd0, biu_type2cnt(t)} + 8'd1) << s) - 8'd1;
        end else begin
            m = 8'd0;
        end
        return m;
    endfunction

endpackage

// File: rtl/biu_sram_responder_beat_gen.sv
// Per-beat combinational decode: next burst address, SRAM word address,
// byte enables and the size/alignment/range error check.
module biu_sram_responder_beat_gen
    import biu_sram_responder_pkg::*;
#(
    parameter int ADDR_SIZE = 32,
    parameter int DATA_SIZE = 32,
    parameter int MEM_WORDS = 4096
) (
    input  logic [ADDR_SIZE-1:0]         addr,
    input  biu_size_t                    size,
    input  biu_type_t                    btype,
    output logic [ADDR_SIZE-1:0]         next_addr,
    output logic [DATA_SIZE/8-1:0]       be,
    output logic [$clog2(MEM_WORDS)-1:0] mem_adr,
    output logic                         err
);

    localparam int BW  = DATA_SIZE / 8;
    localparam int LB  = $clog2(BW);
    localparam int MAW = $clog2(MEM_WORDS);
    localparam logic [ADDR_SIZE:0] MEM_BYTES = (ADDR_SIZE + 1)'(MEM_WORDS * BW);

    logic [ADDR_SIZE-1:0] step_s;
    logic [ADDR_SIZE-1:0] mask_s;
    logic [ADDR_SIZE-1:0] incr_s;
    int                   off_s;
    int                   nbytes_s;

    // Address stepping, lane selection and error decode for the current beat
    always_comb begin
        step_s   = ADDR_SIZE'(biu_size2bytes(size));
        mask_s   = ADDR_SIZE'(biu_wrap_mask(btype, size));
        incr_s   = addr + step_s;
        if (biu_is_wrap(btype)) begin
            next_addr = (addr & ~mask_s) | (incr_s & mask_s);
        end else begin
            next_addr = incr_s;
        end
        off_s    = int'(addr[LB-1:0]);
        nbytes_s = int'(biu_size2bytes(size));
        be       = {BW{1'b0}};
        for (int i = 0; i < BW; i++) begin
            be[i] = (i >= off_s) && (i < off_s + nbytes_s);
        end
        mem_adr  = addr[MAW+LB-1:LB];
        err      = (int'(size) > LB)
                || ((addr & (step_s - ADDR_SIZE'(1))) != {ADDR_SIZE{1'b0}})
                || ({1'b0, addr} >= MEM_BYTES);
    end

endmodule

// File: rtl/biu_sram_responder.sv
// BIU target terminating one master port onto a 1-cycle-latency synchronous SRAM;
// issues one beat per cycle and overlaps the next request with the last beat.
module biu_sram_responder
    import biu_sram_responder_pkg::*;
#(
    parameter int ADDR_SIZE = 32,
    parameter int DATA_SIZE = 32,
    parameter int MEM_WORDS = 4096
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         biu_req_i,
    output logic                         biu_req_ack_o,
    output logic                         biu_d_ack_o,
    input  logic [ADDR_SIZE-1:0]         biu_adri_i,
    output logic [ADDR_SIZE-1:0]         biu_adro_o,
    input  biu_size_t                    biu_size_i,
    input  biu_type_t                    biu_type_i,
    input  logic                         biu_lock_i,
    input  biu_prot_t                    biu_prot_i,
    input  logic                         biu_we_i,
    input  logic [DATA_SIZE-1:0]         biu_d_i,
    output logic [DATA_SIZE-1:0]         biu_q_o,
    output logic                         biu_ack_o,
    output logic                         biu_err_o,
    output logic                         mem_cs_o,
    output logic                         mem_we_o,
    output logic [$clog2(MEM_WORDS)-1:0] mem_adr_o,
    output logic [DATA_SIZE/8-1:0]       mem_be_o,
    output logic [DATA_SIZE-1:0]         mem_d_o,
    input  logic [DATA_SIZE-1:0]         mem_q_i
);

    localparam int BW  = DATA_SIZE / 8;
    localparam int MAW = $clog2(MEM_WORDS);

    resp_state_t          state_r;
    logic [4:0]           cnt_r;
    logic [ADDR_SIZE-1:0] addr_r;
    logic                 we_r;
    biu_size_t            size_r;
    biu_type_t            type_r;
    logic                 ack_r;
    logic                 err_r;
    logic [ADDR_SIZE-1:0] adro_r;

    logic                 last_s;
    logic                 idle_acc_s;
    logic                 accept_s;
    logic                 issue_s;
    logic [ADDR_SIZE-1:0] beat_addr_s;
    biu_size_t            beat_size_s;
    biu_type_t            beat_type_s;
    logic                 beat_we_s;
    logic [ADDR_SIZE-1:0] next_addr_s;
    logic [BW-1:0]        beat_be_s;
    logic [MAW-1:0]       beat_madr_s;
    logic                 beat_err_s;
    logic                 unused_s;

    assign unused_s = ^{biu_lock_i, biu_prot_i};

    // Accept/issue decode; an idle accept issues beat 0 straight from the request inputs
    always_comb begin
        last_s = (state_r == ST_BURST) && (cnt_r == 5'd1);
        if (rst_i) begin
            idle_acc_s = 1'b0;
            accept_s   = 1'b0;
            issue_s    = 1'b0;
        end else begin
            idle_acc_s = biu_req_i && (state_r == ST_IDLE);
            accept_s   = idle_acc_s || (biu_req_i && last_s);
            issue_s    = idle_acc_s || (state_r == ST_BURST);
        end
        if (idle_acc_s) begin
            beat_addr_s = biu_adri_i;
            beat_size_s = biu_size_i;
            beat_type_s = biu_type_i;
            beat_we_s   = biu_we_i;
        end else begin
            beat_addr_s = addr_r;
            beat_size_s = size_r;
            beat_type_s = type_r;
            beat_we_s   = we_r;
        end
    end

    biu_sram_responder_beat_gen #(
        .ADDR_SIZE (ADDR_SIZE),
        .DATA_SIZE (DATA_SIZE),
        .MEM_WORDS (MEM_WORDS)
    ) u_beat_gen (
        .addr      (beat_addr_s),
        .size      (beat_size_s),
        .btype     (beat_type_s),
        .next_addr (next_addr_s),
        .be        (beat_be_s),
        .mem_adr   (beat_madr_s),
        .err       (beat_err_s)
    );

    assign biu_req_ack_o = accept_s;
    assign biu_d_ack_o   = issue_s;
    assign mem_cs_o      = issue_s && !beat_err_s;
    assign mem_we_o      = issue_s && !beat_err_s && beat_we_s;
    assign mem_adr_o     = beat_madr_s;
    assign mem_be_o      = beat_be_s;
    assign mem_d_o       = biu_d_i;
    assign biu_q_o       = mem_q_i;
    assign biu_ack_o     = ack_r;
    assign biu_err_o     = err_r;
    assign biu_adro_o    = adro_r;

    // Burst FSM, beat counter, latched command and registered beat response
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= ST_IDLE;
            cnt_r   <= 5'd0;
            addr_r  <= {ADDR_SIZE{1'b0}};
            we_r    <= 1'b0;
            size_r  <= BYTE;
            type_r  <= SINGLE;
            ack_r   <= 1'b0;
            err_r   <= 1'b0;
            adro_r  <= {ADDR_SIZE{1'b0}};
        end else begin
            ack_r <= issue_s && !beat_err_s;
            err_r <= issue_s && beat_err_s;
            if (issue_s) begin
                adro_r <= beat_addr_s;
                addr_r <= next_addr_s;
            end
            case (state_r)
                ST_IDLE: begin
                    if (idle_acc_s) begin
                        we_r   <= biu_we_i;
                        size_r <= biu_size_i;
                        type_r <= biu_type_i;
                        cnt_r  <= {1'b0, biu_type2cnt(biu_type_i)};
                        if (biu_type2cnt(biu_type_i) == 4'd0) begin
                            state_r <= ST_IDLE;
                        end else begin
                            state_r <= ST_BURST;
                        end
                    end
                end
                ST_BURST: begin
                    if (last_s) begin
                        // A request taken on the last beat starts its beat 0 next cycle
                        if (accept_s) begin
                            we_r    <= biu_we_i;
                            size_r  <= biu_size_i;
                            type_r  <= biu_type_i;
                            addr_r  <= biu_adri_i;
                            cnt_r   <= {1'b0, biu_type2cnt(biu_type_i)} + 5'd1;
                            state_r <= ST_BURST;
                        end else begin
                            cnt_r   <= 5'd0;
                            state_r <= ST_IDLE;
                        end
                    end else begin
                        cnt_r <= cnt_r - 5'd1;
                    end
                end
                default: begin
                    cnt_r   <= 5'd0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_biu_sram_responder.sv
// Self-checking bench for biu_sram_responder: directed and random bursts against
// a transaction-level model of burst addressing, beat timing and memory contents.
module tb_biu_sram_responder;
    import biu_sram_responder_pkg::*;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        biu_req_i;
    logic        biu_req_ack_o;
    logic        biu_d_ack_o;
    logic [31:0] biu_adri_i;
    logic [31:0] biu_adro_o;
    biu_size_t   biu_size_i;
    biu_type_t   biu_type_i;
    logic        biu_lock_i;
    biu_prot_t   biu_prot_i;
    logic        biu_we_i;
    logic [31:0] biu_d_i;
    logic [31:0] biu_q_o;
    logic        biu_ack_o;
    logic        biu_err_o;
    logic        mem_cs_o;
    logic        mem_we_o;
    logic [11:0] mem_adr_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_d_o;
    logic [31:0] mem_q;

    always #5 clk = ~clk;

    biu_sram_responder #(.ADDR_SIZE(32), .DATA_SIZE(32), .MEM_WORDS(4096)) dut (
        .clk_i(clk), .rst_i(rst_i), .biu_req_i(biu_req_i), .biu_req_ack_o(biu_req_ack_o),
        .biu_d_ack_o(biu_d_ack_o), .biu_adri_i(biu_adri_i), .biu_adro_o(biu_adro_o),
        .biu_size_i(biu_size_i), .biu_type_i(biu_type_i), .biu_lock_i(biu_lock_i),
        .biu_prot_i(biu_prot_i), .biu_we_i(biu_we_i), .biu_d_i(biu_d_i), .biu_q_o(biu_q_o),
        .biu_ack_o(biu_ack_o), .biu_err_o(biu_err_o), .mem_cs_o(mem_cs_o), .mem_we_o(mem_we_o),
        .mem_adr_o(mem_adr_o), .mem_be_o(mem_be_o), .mem_d_o(mem_d_o), .mem_q_i(mem_q)
    );

    // SRAM the responder drives: byte-enabled write, 1-cycle registered read
    logic [31:0] sram [0:4095];
    always @(posedge clk) begin
        if (mem_cs_o) begin
            if (mem_we_o) begin
                for (int i = 0; i < 4; i++)
                    if (mem_be_o[i]) sram[mem_adr_o][8*i +: 8] <= mem_d_o[8*i +: 8];
            end else begin
                mem_q <= sram[mem_adr_o];
            end
        end
    end

    typedef struct {
        logic        we;
        int          size;
        biu_type_t   typ;
        logic [31:0] addr;
        int          gap;
        int          base;
    } cmd_t;

    typedef struct {
        logic [31:0] addr;
        logic        err;
        logic        we;
        logic [3:0]  be;
        logic [31:0] data;
    } beat_t;

    cmd_t        cmdq [$];
    beat_t       bq [$];
    logic [31:0] dpool [$];
    logic [31:0] refm [0:4095];
    int          rem;
    int          vectors;
    int          miscompares;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int nbeats(biu_type_t t);
        case (t)
            WRAP4, INCR4:   return 4;
            WRAP8, INCR8:   return 8;
            WRAP16, INCR16: return 16;
            default:        return 1;
        endcase
    endfunction

    task automatic add_cmd(input logic we, input int size, input biu_type_t typ,
                           input logic [31:0] addr, input int gap,
                           input bit seq, input logic [31:0] d0);
        cmd_t c;
        c.we = we; c.size = size; c.typ = typ; c.addr = addr; c.gap = gap; c.base = dpool.size();
        for (int k = 0; k < nbeats(typ); k++)
            dpool.push_back(seq ? d0 + 32'(k) : $urandom);
        cmdq.push_back(c);
    endtask

    // Expand an accepted command into its beats from the burst rules
    task automatic push_beats(input cmd_t c);
        int          n;
        logic [31:0] nb, span, a, off;
        beat_t       b;
        n    = nbeats(c.typ);
        nb   = 32'd1 << c.size;
        span = 32'(n) * nb;
        for (int k = 0; k < n; k++) begin
            if (c.typ == WRAP4 || c.typ == WRAP8 || c.typ == WRAP16)
                a = (c.addr - (c.addr % span)) + (((c.addr % span) + 32'(k) * nb) % span);
            else
                a = c.addr + 32'(k) * nb;
            off    = a % 32'd4;
            b.addr = a;
            b.we   = c.we;
            b.err  = (c.size > 2) || (a % nb != 32'd0) || (a >= 32'h4000);
            for (int i = 0; i < 4; i++) b.be[i] = (32'(i) >= off) && (32'(i) < off + nb);
            b.data = dpool[c.base + k];
            bq.push_back(b);
        end
        rem += n;
    endtask

    // Cycle loop: present queued commands, predict req_ack/d_ack and check every beat
    task automatic run(input int rst_at);
        int    cyc = 0;
        int    quiet = 0;
        bit    pv = 1'b0;
        bit    present;
        bit    acc;
        bit    finished = 1'b0;
        beat_t pb;
        cmd_t  h;
        while (cyc < 3000 && !finished) begin
            @(posedge clk); #1;
            present = (cmdq.size() > 0) && (cmdq[0].gap == 0) && (cyc != rst_at);
            rst_i   = (cyc == rst_at);
            if (present) begin
                h = cmdq[0];
                biu_req_i  = 1'b1;
                biu_adri_i = h.addr;
                biu_size_i = biu_size_t'(h.size);
                biu_type_i = h.typ;
                biu_we_i   = h.we;
            end else begin
                biu_req_i  = 1'b0;
                biu_adri_i = $urandom;
            end
            if (bq.size() > 0) biu_d_i = bq[0].data;
            else if (present)  biu_d_i = dpool[h.base];
            else               biu_d_i = $urandom;
            @(negedge clk);
            if (pv) begin
                chk("ack", biu_ack_o, !pb.err);
                chk("err", biu_err_o, pb.err);
                chk("adro", biu_adro_o, pb.addr);
                if (!pb.err && !pb.we) chk("q", biu_q_o, pb.data);
            end else begin
                chk("ack_idle", biu_ack_o, 1'b0);
                chk("err_idle", biu_err_o, 1'b0);
            end
            if (cyc == rst_at) begin
                chk("rst_req_ack", biu_req_ack_o, 1'b0);
                chk("rst_d_ack", biu_d_ack_o, 1'b0);
                chk("rst_mem_cs", mem_cs_o, 1'b0);
                bq.delete();
                cmdq.delete();
                rem = 0;
                pv  = 1'b0;
            end else begin
                acc = present && (rem <= 1);
                chk("req_ack", biu_req_ack_o, acc);
                if (acc) begin
                    h = cmdq.pop_front();
                    push_beats(h);
                end
                chk("d_ack", biu_d_ack_o, rem > 0);
                if (rem > 0) begin
                    pb = bq.pop_front();
                    rem--;
                    chk("mem_cs", mem_cs_o, !pb.err);
                    if (!pb.err) begin
                        chk("mem_we", mem_we_o, pb.we);
                        chk("mem_adr", mem_adr_o, pb.addr[13:2]);
                        chk("mem_be", mem_be_o, pb.be);
                        if (pb.we) begin
                            chk("mem_d", mem_d_o, pb.data);
                            for (int i = 0; i < 4; i++)
                                if (pb.be[i]) refm[pb.addr[13:2]][8*i +: 8] = pb.data[8*i +: 8];
                        end else begin
                            pb.data = refm[pb.addr[13:2]];
                        end
                    end
                    pv = 1'b1;
                end else begin
                    chk("mem_cs_idle", mem_cs_o, 1'b0);
                    pv = 1'b0;
                end
                if (!present && cmdq.size() > 0 && cmdq[0].gap > 0) begin
                    h = cmdq.pop_front();
                    h.gap--;
                    cmdq.push_front(h);
                end
            end
            if (cmdq.size() == 0 && rem == 0 && !pv) quiet++;
            else quiet = 0;
            finished = (quiet >= 2);
            cyc++;
        end
        chk("run_done", finished, 1'b1);
        #1 rst_i = 1'b0;
    endtask

    initial begin
        int          sz;
        logic [31:0] a;
        vectors = 0; miscompares = 0; rem = 0;
        for (int i = 0; i < 4096; i++) begin sram[i] = 32'd0; refm[i] = 32'd0; end
        mem_q = 32'd0;
        biu_lock_i = 1'b0; biu_prot_i = 3'd0; biu_we_i = 1'b0; biu_d_i = 32'd0;
        biu_adri_i = 32'h100; biu_size_i = WORD; biu_type_i = SINGLE;

        // Reset state: request held high must not be accepted
        rst_i = 1'b1; biu_req_i = 1'b1;
        @(negedge clk);
        chk("reset_req_ack", biu_req_ack_o, 1'b0);
        chk("reset_d_ack", biu_d_ack_o, 1'b0);
        chk("reset_mem_cs", mem_cs_o, 1'b0);
        chk("reset_mem_we", mem_we_o, 1'b0);
        @(negedge clk);
        chk("reset_ack", biu_ack_o, 1'b0);
        chk("reset_err", biu_err_o, 1'b0);
        chk("reset_adro", biu_adro_o, 32'd0);
        @(posedge clk); #1;
        rst_i = 1'b0; biu_req_i = 1'b0;

        // SINGLE write then read
        add_cmd(1'b1, 2, SINGLE, 32'h100, 0, 1'b1, 32'hDEADBEEF);
        add_cmd(1'b0, 2, SINGLE, 32'h100, 1, 1'b0, 32'd0);
        run(-1);
        // INCR4 write 1..4 then INCR4 read
        add_cmd(1'b1, 2, INCR4, 32'h200, 0, 1'b1, 32'd1);
        add_cmd(1'b0, 2, INCR4, 32'h200, 2, 1'b0, 32'd0);
        run(-1);
        // WRAP4 read from mid-window, byte write to top lane
        add_cmd(1'b0, 2, WRAP4, 32'h30C, 0, 1'b0, 32'd0);
        add_cmd(1'b1, 0, SINGLE, 32'h003, 1, 1'b0, 32'd0);
        add_cmd(1'b0, 2, SINGLE, 32'h000, 1, 1'b0, 32'd0);
        run(-1);
        // Back-to-back INCR4 read then INCR8 read with no bubble
        add_cmd(1'b0, 2, INCR4, 32'h200, 0, 1'b0, 32'd0);
        add_cmd(1'b0, 2, INCR8, 32'h100, 0, 1'b0, 32'd0);
        run(-1);
        // Error beats: misaligned, out of range, burst crossing the top
        add_cmd(1'b0, 1, SINGLE, 32'h101, 0, 1'b0, 32'd0);
        add_cmd(1'b0, 2, SINGLE, 32'h4000, 1, 1'b0, 32'd0);
        add_cmd(1'b0, 2, INCR4, 32'h3FF8, 1, 1'b0, 32'd0);
        add_cmd(1'b0, 3, SINGLE, 32'h100, 1, 1'b0, 32'd0);
        run(-1);
        // Reset during the 3rd beat of INCR8, then a normal SINGLE
        add_cmd(1'b0, 2, INCR8, 32'h400, 0, 1'b0, 32'd0);
        run(2);
        add_cmd(1'b0, 2, SINGLE, 32'h204, 0, 1'b0, 32'd0);
        run(-1);
        // Random bursts with random gaps, sizes and occasional misalignment
        for (int n = 0; n < 40; n++) begin
            sz = int'($urandom_range(0, 3));
            a  = $urandom_range(0, 16383) & ~((32'd1 << sz) - 32'd1);
            if ($urandom_range(0, 9) == 0) a = a | 32'd1;
            add_cmd(1'($urandom_range(0, 1)), sz, biu_type_t'($urandom_range(0, 7)), a,
                    int'($urandom_range(0, 2)), 1'b0, 32'd0);
        end
        run(-1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
